// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2,
    FLUSH    = 2'd3
  } hz_state_t;

  localparam int REG_ADDR_W = 5;
  localparam int PERF_W     = 32;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three free-running event counters (load-use stall, flush, freeze cycles).
// Latency: count visible one cycle after the enabling cycle.
// Backpressure: none; counters wrap at 2^PERF_W.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en_stall,
  input  logic              i_en_flush,
  input  logic              i_en_freeze,
  output logic [PERF_W-1:0] o_stall,
  output logic [PERF_W-1:0] o_flush,
  output logic [PERF_W-1:0] o_freeze
);

  logic [PERF_W-1:0] r_stall;
  logic [PERF_W-1:0] r_flush;
  logic [PERF_W-1:0] r_freeze;

  // Count enabled cycles; synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall  <= '0;
      r_flush  <= '0;
      r_freeze <= '0;
    end else begin
      if (i_en_stall)  r_stall  <= r_stall  + 1'b1;
      if (i_en_flush)  r_flush  <= r_flush  + 1'b1;
      if (i_en_freeze) r_freeze <= r_freeze + 1'b1;
    end
  end

  assign o_stall  = r_stall;
  assign o_flush  = r_flush;
  assign o_freeze = r_freeze;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer driving all 5-stage pipeline register enables.
// Latency: 0 cycles (Mealy outputs from state + inputs).
// Backpressure: im_stall/dm_stall freeze every stage; a branch seen while frozen is replayed on release.
// Optional perf counters enabled with `define HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_SLOTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ID_rs2_addr,
  input  logic                  ID_use_rs1,
  input  logic                  ID_use_rs2,
  input  logic                  EXE_MemRead,
  input  logic [REG_ADDR_W-1:0] EXE_rd_addr,
  input  logic                  EXE_br_taken,
  input  logic                  im_stall,
  input  logic                  dm_stall,
  output logic                  PC_write,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EXE_write,
  output logic                  ID_EXE_bubble,
  output logic                  EXE_MEM_write,
  output logic                  MEM_WB_write,
  output logic [PERF_W-1:0]     perf_stall,
  output logic [PERF_W-1:0]     perf_flush,
  output logic [PERF_W-1:0]     perf_freeze
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS - 1);

  hz_state_t  r_state, w_state_nxt;
  logic [2:0] r_flush_cnt, w_flush_cnt_nxt;
  logic       r_flush_pend, w_flush_pend_nxt;
  logic       w_lu, w_freeze, w_br_eff;

  assign w_lu = EXE_MemRead && (EXE_rd_addr != '0) &&
                ((ID_use_rs1 && (ID_rs1_addr == EXE_rd_addr)) ||
                 (ID_use_rs2 && (ID_rs2_addr == EXE_rd_addr)));
  assign w_freeze = im_stall || dm_stall;
  // A branch deferred across a freeze is replayed as if it resolved now.
  assign w_br_eff = EXE_br_taken || ((r_state == FREEZE) && r_flush_pend);

  // State, flush slot counter and deferred-flush flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= RUN;
      r_flush_cnt  <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  // Next state and enables; priority freeze > flush > load-use > run.
  always_comb begin
    PC_write         = 1'b1;
    IF_ID_write      = 1'b1;
    IF_ID_flush      = 1'b0;
    ID_EXE_write     = 1'b1;
    ID_EXE_bubble    = 1'b0;
    EXE_MEM_write    = 1'b1;
    MEM_WB_write     = 1'b1;
    w_state_nxt      = RUN;
    w_flush_cnt_nxt  = r_flush_cnt;
    w_flush_pend_nxt = r_flush_pend;

    if (!rst) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EXE_write  = 1'b0;
      EXE_MEM_write = 1'b0;
      MEM_WB_write  = 1'b0;
    end else if (w_freeze) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EXE_write  = 1'b0;
      EXE_MEM_write = 1'b0;
      MEM_WB_write  = 1'b0;
      w_state_nxt   = FREEZE;
      // An interrupted flush restarts with its full slot count on release.
      if ((r_state == FLUSH) || EXE_br_taken)
        w_flush_pend_nxt = 1'b1;
    end else if (r_state == FLUSH) begin
      // EXE holds a bubble here, so no new branch can resolve.
      IF_ID_flush     = 1'b1;
      w_flush_cnt_nxt = r_flush_cnt - 3'd1;
      w_state_nxt     = (r_flush_cnt == 3'd1) ? RUN : FLUSH;
    end else if (w_br_eff) begin
      IF_ID_flush      = 1'b1;
      ID_EXE_bubble    = 1'b1;
      w_flush_cnt_nxt  = FLUSH_INIT;
      w_flush_pend_nxt = 1'b0;
      w_state_nxt      = (FLUSH_SLOTS > 1) ? FLUSH : RUN;
    end else if (w_lu && (r_state != LU_STALL)) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EXE_bubble = 1'b1;
      w_state_nxt   = LU_STALL;
    end
  end

`ifdef HAZARD_PERF_EN
  logic w_en_stall, w_en_freeze;

  // With reset high and no freeze, PC_write drops only for a load-use stall.
  assign w_en_stall  = rst && !w_freeze && !PC_write;
  assign w_en_freeze = rst && w_freeze;

  hazard_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_en_stall  (w_en_stall),
    .i_en_flush  (IF_ID_flush),
    .i_en_freeze (w_en_freeze),
    .o_stall     (perf_stall),
    .o_flush     (perf_flush),
    .o_freeze    (perf_freeze)
  );
`else
  assign perf_stall  = '0;
  assign perf_flush  = '0;
  assign perf_freeze = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with FLUSH_SLOTS=2.
// Latency: outputs checked in the same cycle the inputs are applied.
// Backpressure: freeze sequences covered by vector table and a hand-written run.
module tb_pipeline_hazard_ctrl;

  // Expected enable patterns {PC, IF_ID_w, IF_ID_flush, ID_EXE_w, ID_EXE_bubble, EXE_MEM_w, MEM_WB_w}
  localparam logic [6:0] O_RST = 7'b0000000;
  localparam logic [6:0] O_FRZ = 7'b0000000;
  localparam logic [6:0] O_RUN = 7'b1101011;
  localparam logic [6:0] O_LU  = 7'b0001111;
  localparam logic [6:0] O_BR  = 7'b1111111;
  localparam logic [6:0] O_FL  = 7'b1111011;

`ifdef HAZARD_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       ims;
    logic       dms;
    logic [6:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs1_addr, ID_rs2_addr, EXE_rd_addr;
  logic        ID_use_rs1, ID_use_rs2, EXE_MemRead, EXE_br_taken, im_stall, dm_stall;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EXE_write, ID_EXE_bubble;
  logic        EXE_MEM_write, MEM_WB_write;
  logic [31:0] perf_stall, perf_flush, perf_freeze;

  logic [6:0]  exp_q[$];
  vec_t        tbl[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] m_stall = 0, m_flush = 0, m_freeze = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_SLOTS(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .ID_rs1_addr   (ID_rs1_addr),
    .ID_rs2_addr   (ID_rs2_addr),
    .ID_use_rs1    (ID_use_rs1),
    .ID_use_rs2    (ID_use_rs2),
    .EXE_MemRead   (EXE_MemRead),
    .EXE_rd_addr   (EXE_rd_addr),
    .EXE_br_taken  (EXE_br_taken),
    .im_stall      (im_stall),
    .dm_stall      (dm_stall),
    .PC_write      (PC_write),
    .IF_ID_write   (IF_ID_write),
    .IF_ID_flush   (IF_ID_flush),
    .ID_EXE_write  (ID_EXE_write),
    .ID_EXE_bubble (ID_EXE_bubble),
    .EXE_MEM_write (EXE_MEM_write),
    .MEM_WB_write  (MEM_WB_write),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush),
    .perf_freeze   (perf_freeze)
  );

  function automatic vec_t mk(string name, logic r, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic mr, logic [4:0] rd,
                              logic br, logic ims, logic dms, logic [6:0] e);
    vec_t v;
    v.name = name; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.mr = mr; v.rd = rd; v.br = br; v.ims = ims; v.dms = dms; v.exp = e;
    return v;
  endfunction

  function automatic vec_t idle(string name, logic [6:0] e);
    return mk(name, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, e);
  endfunction

  function automatic vec_t lu5(string name, logic ims, logic [6:0] e);
    return mk(name, 1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, ims, 1'b0, e);
  endfunction

  task automatic check32(string name, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  // One cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input vec_t v);
    logic [6:0] got, e;
    @(posedge clk);
    #1;
    rst          = v.rst;
    ID_rs1_addr  = v.rs1;
    ID_rs2_addr  = v.rs2;
    ID_use_rs1   = v.u1;
    ID_use_rs2   = v.u2;
    EXE_MemRead  = v.mr;
    EXE_rd_addr  = v.rd;
    EXE_br_taken = v.br;
    im_stall     = v.ims;
    dm_stall     = v.dms;
    exp_q.push_back(v.exp);
    @(negedge clk);
    got = {PC_write, IF_ID_write, IF_ID_flush, ID_EXE_write, ID_EXE_bubble,
           EXE_MEM_write, MEM_WB_write};
    e = exp_q.pop_front();
    n_total++;
    if (got === e) n_pass++;
    else $display("FAIL %s enables: got %b expected %b", v.name, got, e);
    check32({v.name, " perf_stall"},  perf_stall,  m_stall);
    check32({v.name, " perf_flush"},  perf_flush,  m_flush);
    check32({v.name, " perf_freeze"}, perf_freeze, m_freeze);
    // Counter model: effect of this cycle lands at the next rising edge.
    if (PERF_ON) begin
      if (!v.rst) begin
        m_stall = 0; m_flush = 0; m_freeze = 0;
      end else begin
        if (e == O_LU)       m_stall++;
        if (e[4])            m_flush++;
        if (v.ims || v.dms)  m_freeze++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; ID_rs1_addr = '0; ID_rs2_addr = '0; ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
    EXE_MemRead = 1'b0; EXE_rd_addr = '0; EXE_br_taken = 1'b0; im_stall = 1'b0; dm_stall = 1'b0;

    tbl.push_back(mk("reset0", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_RST));
    tbl.push_back(mk("reset1", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST));
    tbl.push_back(idle("run_idle", O_RUN));
    tbl.push_back(lu5("lu_rs1", 1'b0, O_LU));
    tbl.push_back(lu5("lu_no_b2b", 1'b0, O_RUN));
    tbl.push_back(idle("run_after_lu", O_RUN));
    tbl.push_back(mk("x0_load", 1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(mk("rs2_unused", 1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN));
    tbl.push_back(mk("lu_rs2", 1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU));
    tbl.push_back(idle("lu_rs2_done", O_RUN));
    tbl.push_back(mk("br_taken", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR));
    tbl.push_back(idle("flush_slot2", O_FL));
    tbl.push_back(idle("flush_done", O_RUN));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("dm_frz%0d", i), 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0,
                       1'b1, 1'b0, 1'b1, O_FRZ));
    tbl.push_back(idle("frz_rel_br", O_BR));
    tbl.push_back(idle("frz_rel_fl", O_FL));
    tbl.push_back(idle("frz_rel_run", O_RUN));
    tbl.push_back(lu5("lu_vs_im", 1'b1, O_FRZ));
    tbl.push_back(lu5("lu_after_frz", 1'b0, O_LU));
    tbl.push_back(lu5("lu_after_frz2", 1'b0, O_RUN));
    tbl.push_back(mk("br2", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR));
    tbl.push_back(mk("frz_in_flush", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_FRZ));
    tbl.push_back(idle("flush_restart", O_BR));
    tbl.push_back(idle("flush_restart2", O_FL));
    tbl.push_back(idle("restart_done", O_RUN));
    tbl.push_back(mk("br3", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR));
    tbl.push_back(mk("rst_in_flush", 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST));
    tbl.push_back(idle("run_after_rst", O_RUN));
    tbl.push_back(lu5("lu_post_rst", 1'b0, O_LU));
    tbl.push_back(idle("post_lu", O_RUN));

    foreach (tbl[i]) step(tbl[i]);

    // Branch arrives mid-freeze only, then release replays a full flush.
    step(mk("hs_frz_a", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_FRZ));
    step(mk("hs_frz_br", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, O_FRZ));
    step(mk("hs_frz_c", 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_FRZ));
    step(idle("hs_rel_br", O_BR));
    step(idle("hs_rel_fl", O_FL));
    step(idle("hs_done", O_RUN));
    // Load with rs1 match but rs1 unused and rs2 different: no stall.
    step(mk("hs_rs1_unused", 1'b1, 5'd8, 5'd4, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, O_RUN));
    step(idle("hs_end", O_RUN));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
